// File: rtl/poly_tile_scheduler_if.sv
// Bundle of host, coefficient-buffer and poly_mult_top signals around the tile scheduler.
// master = scheduler side, slave = surrounding environment.
interface poly_tile_scheduler_if #(
   parameter int DATA_WIDTH        = 64,
   parameter int POLY_A_TILE_WIDTH = 8,
   parameter int POLY_B_TILE_WIDTH = 8,
   parameter int A_ADDR_WIDTH      = 3,
   parameter int B_ADDR_WIDTH      = 3,
   parameter int OFFSET_WIDTH      = 7
);
   logic                                      start;
   logic                                      busy;
   logic                                      done;
   logic                                      a_rd_en;
   logic [A_ADDR_WIDTH-1:0]                   a_rd_addr;
   logic [POLY_A_TILE_WIDTH*DATA_WIDTH-1:0]   a_rd_data;
   logic                                      b_rd_en;
   logic [B_ADDR_WIDTH-1:0]                   b_rd_addr;
   logic [POLY_B_TILE_WIDTH*DATA_WIDTH-1:0]   b_rd_data;
   logic [POLY_A_TILE_WIDTH*DATA_WIDTH-1:0]   tile_a;
   logic [POLY_B_TILE_WIDTH*DATA_WIDTH-1:0]   tile_b;
   logic                                      inputs_ready_signal;
   logic                                      outputs_ready_signal;
   logic                                      c_valid;
   logic [OFFSET_WIDTH-1:0]                   c_offset;
   logic                                      err;

   modport master (
      input  start, a_rd_data, b_rd_data, outputs_ready_signal,
      output busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
             tile_a, tile_b, inputs_ready_signal, c_valid, c_offset, err
   );

   modport slave (
      output start, a_rd_data, b_rd_data, outputs_ready_signal,
      input  busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
             tile_a, tile_b, inputs_ready_signal, c_valid, c_offset, err
   );
endinterface

// File: rtl/poly_tile_scheduler.sv
// Sequences every (i, j) tile pair of A x B through poly_mult_top, j inner / i outer.
// Optional WAIT watchdog enabled by defining POLY_SCHED_TIMEOUT_EN.
module poly_tile_scheduler #(
   parameter int DATA_WIDTH        = 64,
   parameter int POLY_A_WIDTH      = 64,
   parameter int POLY_B_WIDTH      = 64,
   parameter int POLY_A_TILE_WIDTH = 8,
   parameter int POLY_B_TILE_WIDTH = 8
`ifdef POLY_SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES    = 1024
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   poly_tile_scheduler_if.master bus
);
   localparam int NA  = POLY_A_WIDTH / POLY_A_TILE_WIDTH;
   localparam int NB  = POLY_B_WIDTH / POLY_B_TILE_WIDTH;
   localparam int CW  = $clog2(POLY_A_WIDTH + POLY_B_WIDTH - 1);
   localparam int AW  = (NA > 1) ? $clog2(NA) : 1;
   localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
   localparam int TAW = POLY_A_TILE_WIDTH * DATA_WIDTH;
   localparam int TBW = POLY_B_TILE_WIDTH * DATA_WIDTH;
`ifdef POLY_SCHED_TIMEOUT_EN
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_LOAD    = 3'd2,
      S_ISSUE   = 3'd3,
      S_WAIT    = 3'd4,
      S_ADVANCE = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t           state_r;
   logic [AW-1:0]    i_r;
   logic [BW-1:0]    j_r;
   logic             busy_r;
   logic             done_r;
   logic             rd_en_r;
   logic             issue_r;
   logic             c_valid_r;
   logic [CW-1:0]    c_offset_r;
   logic [TAW-1:0]   tile_a_r;
   logic [TBW-1:0]   tile_b_r;
   logic [CW-1:0]    offset_s;
`ifdef POLY_SCHED_TIMEOUT_EN
   logic             err_r;
   logic [TW-1:0]    wait_cnt_r;
`endif

   // Base coefficient index of the current tile pair's partial product.
   always_comb begin
      offset_s = CW'(i_r) * CW'(POLY_A_TILE_WIDTH) + CW'(j_r) * CW'(POLY_B_TILE_WIDTH);
   end

   // Scheduler FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         i_r        <= '0;
         j_r        <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         rd_en_r    <= 1'b0;
         issue_r    <= 1'b0;
         c_valid_r  <= 1'b0;
         c_offset_r <= '0;
         tile_a_r   <= '0;
         tile_b_r   <= '0;
`ifdef POLY_SCHED_TIMEOUT_EN
         err_r      <= 1'b0;
         wait_cnt_r <= '0;
`endif
      end else begin
         rd_en_r   <= 1'b0;
         issue_r   <= 1'b0;
         c_valid_r <= 1'b0;
         done_r    <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  i_r     <= '0;
                  j_r     <= '0;
                  rd_en_r <= 1'b1;
                  busy_r  <= 1'b1;
`ifdef POLY_SCHED_TIMEOUT_EN
                  err_r   <= 1'b0;
`endif
                  state_r <= S_FETCH;
               end
            end
            S_FETCH: state_r <= S_LOAD;
            S_LOAD: begin
               tile_a_r <= bus.a_rd_data;
               tile_b_r <= bus.b_rd_data;
               issue_r  <= 1'b1;
               state_r  <= S_ISSUE;
            end
            S_ISSUE: begin
`ifdef POLY_SCHED_TIMEOUT_EN
               wait_cnt_r <= '0;
`endif
               state_r <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.outputs_ready_signal) begin
                  c_valid_r  <= 1'b1;
                  c_offset_r <= offset_s;
                  state_r    <= S_ADVANCE;
               end
`ifdef POLY_SCHED_TIMEOUT_EN
               // Watchdog abandons the run silently: no c_valid, no done.
               else if (wait_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                  err_r   <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + TW'(1);
               end
`endif
            end
            S_ADVANCE: begin
               if (j_r != BW'(NB - 1)) begin
                  j_r     <= j_r + BW'(1);
                  rd_en_r <= 1'b1;
                  state_r <= S_FETCH;
               end else if (i_r != AW'(NA - 1)) begin
                  j_r     <= '0;
                  i_r     <= i_r + AW'(1);
                  rd_en_r <= 1'b1;
                  state_r <= S_FETCH;
               end else begin
                  done_r  <= 1'b1;
                  state_r <= S_DONE;
               end
            end
            S_DONE: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy                = busy_r;
   assign bus.done                = done_r;
   assign bus.a_rd_en             = rd_en_r;
   assign bus.b_rd_en             = rd_en_r;
   assign bus.a_rd_addr           = i_r;
   assign bus.b_rd_addr           = j_r;
   assign bus.tile_a              = tile_a_r;
   assign bus.tile_b              = tile_b_r;
   assign bus.inputs_ready_signal = issue_r;
   assign bus.c_valid             = c_valid_r;
   assign bus.c_offset            = c_offset_r;
`ifdef POLY_SCHED_TIMEOUT_EN
   assign bus.err                 = err_r;
`else
   assign bus.err                 = 1'b0;
`endif
endmodule

// File: tb/tb_poly_tile_scheduler.sv
// Scoreboard bench: 8x8-tile default instance plus a single-pair (NA=NB=1) instance.
module tb_poly_tile_scheduler;
   localparam int DW = 64;
   localparam int TA = 8;
   localparam int TB = 8;
   localparam int NB = 8;
   localparam int NP = 64;
   localparam int CW = 7;

   typedef struct {
      int off;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   poly_tile_scheduler_if #(.DATA_WIDTH(DW), .POLY_A_TILE_WIDTH(TA), .POLY_B_TILE_WIDTH(TB),
                            .A_ADDR_WIDTH(3), .B_ADDR_WIDTH(3), .OFFSET_WIDTH(CW)) bus_a();
   poly_tile_scheduler_if #(.DATA_WIDTH(DW), .POLY_A_TILE_WIDTH(64), .POLY_B_TILE_WIDTH(64),
                            .A_ADDR_WIDTH(1), .B_ADDR_WIDTH(1), .OFFSET_WIDTH(CW)) bus_1();

   poly_tile_scheduler #(
      .DATA_WIDTH(DW), .POLY_A_WIDTH(64), .POLY_B_WIDTH(64),
      .POLY_A_TILE_WIDTH(TA), .POLY_B_TILE_WIDTH(TB)
`ifdef POLY_SCHED_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_a));

   poly_tile_scheduler #(
      .DATA_WIDTH(DW), .POLY_A_WIDTH(64), .POLY_B_WIDTH(64),
      .POLY_A_TILE_WIDTH(64), .POLY_B_TILE_WIDTH(64)
`ifdef POLY_SCHED_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus_1));

   assign bus_1.a_rd_data = {64{64'd1}};
   assign bus_1.b_rd_data = {64{64'd100}};

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb_q[$];
   int   pair_k, n_issue, n_cvalid, n_done, last_off, last_cv_cyc;
   logic inject_en;
   logic mult_en;

   function automatic logic [TA*DW-1:0] tile_pat(input logic [63:0] v);
      logic [TA*DW-1:0] r;
      for (int k = 0; k < TA; k++) r[k*DW +: DW] = v;
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
   endtask

   // Coefficient buffers: tagged data appears only in the cycle after a read strobe.
   logic       a_req, b_req;
   logic [2:0] a_addr_q, b_addr_q;
   always @(negedge clk) begin
      a_req = bus_a.a_rd_en;  a_addr_q = bus_a.a_rd_addr;
      b_req = bus_a.b_rd_en;  b_addr_q = bus_a.b_rd_addr;
   end
   always @(posedge clk) begin
      #1;
      bus_a.a_rd_data = a_req ? tile_pat(64'(a_addr_q) + 64'd1)   : {TA*DW{1'b1}};
      bus_a.b_rd_data = b_req ? tile_pat(64'(b_addr_q) + 64'd100) : {TB*DW{1'b1}};
   end

   // Multiplier model: answers 3 cycles after each issue pulse, optionally glitches during ISSUE.
   int mcnt = 0;
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         mcnt = 0;
         bus_a.outputs_ready_signal = 1'b0;
      end else if (bus_a.inputs_ready_signal) begin
         mcnt = 3;
         bus_a.outputs_ready_signal = inject_en;
      end else if (mcnt > 0) begin
         mcnt--;
         bus_a.outputs_ready_signal = (mcnt == 0) && mult_en;
      end else begin
         bus_a.outputs_ready_signal = 1'b0;
      end
   end

   task automatic monitor_loop();
      exp_t e;
      int   ei, ej;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb_q.delete();
         end else begin
            if (bus_a.start && !bus_a.busy) begin
               sb_q.delete();
               pair_k = 0; n_issue = 0; n_cvalid = 0; n_done = 0;
            end
            if (bus_a.inputs_ready_signal) begin
               ei = pair_k / NB;
               ej = pair_k % NB;
               check_eq("issue_tile_a", 64'(bus_a.tile_a == tile_pat(64'(ei + 1))), 64'd1);
               check_eq("issue_tile_b", 64'(bus_a.tile_b == tile_pat(64'(ej + 100))), 64'd1);
               e.off = ei * TA + ej * TB;
               e.cyc = cyc + 4;
               sb_q.push_back(e);
               pair_k++;
               n_issue++;
            end
            if (bus_a.c_valid) begin
               if (sb_q.size() == 0) begin
                  check_eq("c_valid_unexpected", 64'd1, 64'd0);
               end else begin
                  e = sb_q.pop_front();
                  check_eq("c_offset", 64'(bus_a.c_offset), 64'(e.off));
                  check_eq("c_valid_cycle", 64'(cyc), 64'(e.cyc));
               end
               check_eq("busy_at_cvalid", 64'(bus_a.busy), 64'd1);
               n_cvalid++;
               last_off = int'(bus_a.c_offset);
               last_cv_cyc = cyc;
            end
            if (bus_a.done) begin
               n_done++;
               check_eq("done_after_last_cvalid", 64'(cyc), 64'(last_cv_cyc + 1));
               check_eq("cvalid_count_at_done", 64'(n_cvalid), 64'(NP));
            end
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 bus_a.start = 1'b1;
      @(posedge clk); #1 bus_a.start = 1'b0;
   endtask

   task automatic wait_issues(input int n);
      for (int k = 0; k < 3000 && n_issue < n; k++) @(negedge clk);
      check_eq("reach_issue_count", 64'(n_issue >= n), 64'd1);
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 3000 && n_done == 0; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      check_eq({tag, "_done_count"}, 64'(n_done), 64'd1);
      check_eq({tag, "_issue_count"}, 64'(n_issue), 64'(NP));
      check_eq({tag, "_cvalid_count"}, 64'(n_cvalid), 64'(NP));
      check_eq({tag, "_last_offset"}, 64'(last_off), 64'd112);
      check_eq({tag, "_idle_busy"}, 64'(bus_a.busy), 64'd0);
   endtask

   initial begin
      int iss, cv, dn, n1i, n1c;
      rst_n = 1'b0;
      bus_a.start = 1'b0;
      bus_1.start = 1'b0;
      bus_1.outputs_ready_signal = 1'b0;
      inject_en = 1'b0;
      mult_en = 1'b1;
      fork
         monitor_loop();
      join_none
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(bus_a.busy), 64'd0);
      check_eq("rst_done", 64'(bus_a.done), 64'd0);
      check_eq("rst_err", 64'(bus_a.err), 64'd0);
      check_eq("rst_rd_en", 64'(bus_a.a_rd_en | bus_a.b_rd_en), 64'd0);
      check_eq("rst_issue", 64'(bus_a.inputs_ready_signal), 64'd0);
      check_eq("rst_cvalid", 64'(bus_a.c_valid), 64'd0);
      check_eq("rst_offset", 64'(bus_a.c_offset), 64'd0);
      check_eq("rst_tiles_zero", 64'((bus_a.tile_a == '0) && (bus_a.tile_b == '0)), 64'd1);
      @(negedge clk) rst_n = 1'b1;

      // Full product; first read strobe right after start is sampled.
      pulse_start();
      @(negedge clk);
      check_eq("fetch_rd_en", 64'(bus_a.a_rd_en & bus_a.b_rd_en), 64'd1);
      check_eq("fetch_addr", 64'({bus_a.a_rd_addr, bus_a.b_rd_addr}), 64'd0);
      check_eq("fetch_busy", 64'(bus_a.busy), 64'd1);
      wait_done("run1");

      // Start re-pulsed mid-run and ready glitched during every ISSUE.
      inject_en = 1'b1;
      pulse_start();
      wait_issues(10);
      pulse_start();
      wait_done("run2");
      inject_en = 1'b0;

      // Reset during WAIT of pair 20.
      pulse_start();
      wait_issues(21);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_cvalid_before", 64'(n_cvalid), 64'd20);
      check_eq("midrst_busy", 64'(bus_a.busy), 64'd0);
      check_eq("midrst_strobes", 64'({bus_a.a_rd_en, bus_a.inputs_ready_signal, bus_a.c_valid, bus_a.done}), 64'd0);
      check_eq("midrst_offset", 64'(bus_a.c_offset), 64'd0);
      check_eq("midrst_tile_a", 64'(bus_a.tile_a == '0), 64'd1);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("postrst_idle", 64'(bus_a.busy), 64'd0);
      check_eq("postrst_no_done", 64'(n_done), 64'd0);
      pulse_start();
      wait_done("run3");

      // Single-pair instance.
      @(posedge clk); #1 bus_1.start = 1'b1;
      @(posedge clk); #1 bus_1.start = 1'b0;
      iss = -100; cv = -1; dn = -1; n1i = 0; n1c = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         bus_1.outputs_ready_signal = (cyc == iss + 1);
         if (bus_1.inputs_ready_signal) begin
            n1i++;
            iss = cyc;
            check_eq("one_tile_a", 64'(bus_1.tile_a == {64{64'd1}}), 64'd1);
            check_eq("one_tile_b", 64'(bus_1.tile_b == {64{64'd100}}), 64'd1);
         end
         if (bus_1.c_valid) begin
            n1c++;
            cv = cyc;
            check_eq("one_offset", 64'(bus_1.c_offset), 64'd0);
         end
         if (bus_1.done) dn = cyc;
      end
      check_eq("one_issue_count", 64'(n1i), 64'd1);
      check_eq("one_cvalid_count", 64'(n1c), 64'd1);
      check_eq("one_cvalid_latency", 64'(cv), 64'(iss + 2));
      check_eq("one_done_latency", 64'(dn), 64'(cv + 1));
      check_eq("one_idle_busy", 64'(bus_1.busy), 64'd0);

`ifdef POLY_SCHED_TIMEOUT_EN
      // Watchdog: no answer from the multiplier.
      mult_en = 1'b0;
      pulse_start();
      wait_issues(1);
      iss = cyc;
      for (int k = 0; k < 100 && !bus_a.err; k++) @(negedge clk);
      check_eq("wd_err_cycle", 64'(cyc), 64'(iss + 17));
      check_eq("wd_err", 64'(bus_a.err), 64'd1);
      check_eq("wd_idle", 64'(bus_a.busy), 64'd0);
      repeat (4) @(negedge clk);
      check_eq("wd_sticky", 64'(bus_a.err), 64'd1);
      check_eq("wd_no_done", 64'(n_done), 64'd0);
      check_eq("wd_no_cvalid", 64'(n_cvalid), 64'd0);
      mult_en = 1'b1;
      pulse_start();
      @(negedge clk);
      check_eq("wd_err_cleared", 64'(bus_a.err), 64'd0);
      wait_done("run_wd");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
